// File: rtl/exe_stage_mc.sv
// exe_stage_mc: registered execute stage (forwarding, ALU, branch resolution) with a
// valid/ready output register. Defining EXE_MULDIV_EN adds an iterative shift-add
// multiplier and restoring divider (ops C/D/E). Without it, those ops finish in a
// single cycle and return 0.
module exe_stage_mc #(
  parameter int DW       = 16,
  parameter int BR_SHIFT = 2,
  parameter int PC_INC   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] rdata1,
  input  logic [DW-1:0] rdata2,
  input  logic [DW-1:0] imme,
  input  logic [DW-1:0] pc_src,
  input  logic [3:0]    alu_op,
  input  logic [1:0]    ctrl_b,
  input  logic [1:0]    fwd_a,
  input  logic [1:0]    fwd_b,
  input  logic [1:0]    fwd_w,
  input  logic [1:0]    j_or_b,
  input  logic [DW-1:0] alu_back,
  input  logic [DW-1:0] wb_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] alu_res,
  output logic [DW-1:0] wdata,
  output logic [DW-1:0] new_pc,
  output logic          br_taken,
  output logic          busy
);

  localparam int SHW = $clog2(DW);

  localparam logic [3:0] OP_MUL  = 4'hC;
  localparam logic [3:0] OP_DIVU = 4'hD;
  localparam logic [3:0] OP_REMU = 4'hE;

  logic [DW-1:0]  a_s, b_nat_s, b_s, w_s;
  logic [DW-1:0]  alu_s;
  logic [SHW-1:0] sh_s;
  logic [DW-1:0]  target_s, seq_pc_s, pc_s;
  logic           taken_s;
  logic           accept_s, idle_s, is_md_op_s, md_done_s;
  logic [DW-1:0]  md_result_s;

  logic           out_valid_q, out_valid_d;
  logic           br_taken_q, br_taken_d;
  logic [DW-1:0]  alu_res_q, alu_res_d;
  logic [DW-1:0]  wdata_q, wdata_d;
  logic [DW-1:0]  new_pc_q, new_pc_d;

  // Operand selection: B source mux, then forwarding for A, B and store data.
  always_comb begin
    case (ctrl_b)
      2'b00:   b_nat_s = rdata2;
      2'b01:   b_nat_s = imme;
      default: b_nat_s = '0;
    endcase
    case (fwd_a)
      2'b00:   a_s = rdata1;
      2'b01:   a_s = alu_back;
      2'b10:   a_s = wb_data;
      default: a_s = '0;
    endcase
    case (fwd_b)
      2'b00:   b_s = b_nat_s;
      2'b01:   b_s = alu_back;
      2'b10:   b_s = wb_data;
      default: b_s = '0;
    endcase
    case (fwd_w)
      2'b00:   w_s = rdata2;
      2'b01:   w_s = alu_back;
      2'b10:   w_s = wb_data;
      default: w_s = '0;
    endcase
  end

  // Single-cycle ALU; shifts use only the low log2(DW) bits of B.
  always_comb begin
    alu_s = '0;
    sh_s  = b_s[SHW-1:0];
    case (alu_op)
      4'h0:    alu_s = a_s + b_s;
      4'h1:    alu_s = a_s - b_s;
      4'h2:    alu_s = a_s & b_s;
      4'h3:    alu_s = a_s | b_s;
      4'h4:    alu_s = '0 - a_s;
      4'h5:    alu_s = ~a_s;
      4'h6:    alu_s = a_s << sh_s;
      4'h7:    alu_s = a_s >> sh_s;
      4'h8:    alu_s = $signed(a_s) >>> sh_s;
      4'h9:    alu_s = (a_s < b_s) ? {{(DW-1){1'b0}}, 1'b1} : '0;
      4'hA:    alu_s = (a_s == b_s) ? '0 : {{(DW-1){1'b0}}, 1'b1};
      4'hB:    alu_s = pc_src;
      default: alu_s = '0;
    endcase
  end

  // Next-PC resolution: branch target, register jump, or conditional on A.
  always_comb begin
    target_s = pc_src + (imme << BR_SHIFT);
    seq_pc_s = pc_src + DW'(PC_INC);
    pc_s     = seq_pc_s;
    taken_s  = 1'b0;
    case (j_or_b)
      2'b00: begin
        pc_s    = target_s;
        taken_s = 1'b1;
      end
      2'b01: begin
        pc_s    = a_s;
        taken_s = 1'b1;
      end
      2'b10: begin
        if (a_s == '0) begin
          pc_s    = target_s;
          taken_s = 1'b1;
        end else begin
          pc_s    = seq_pc_s;
          taken_s = 1'b0;
        end
      end
      2'b11: begin
        if (a_s != '0) begin
          pc_s    = target_s;
          taken_s = 1'b1;
        end else begin
          pc_s    = seq_pc_s;
          taken_s = 1'b0;
        end
      end
      default: begin
        pc_s    = seq_pc_s;
        taken_s = 1'b0;
      end
    endcase
  end

  // Accept only when idle and the output register is free or being drained.
  assign in_ready = rst & idle_s & (~out_valid_q | out_ready);
  assign accept_s = in_valid & in_ready;

`ifdef EXE_MULDIV_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_e;

  localparam int CW = $clog2(DW + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [DW-1:0] opa_q, opa_d;
  logic [DW-1:0] opb_q, opb_d;
  logic          rem_sel_q, rem_sel_d;
  logic [DW:0]   rem_shift_s, trial_s;
  logic          last_s;

  assign is_md_op_s = (alu_op == OP_MUL) | (alu_op == OP_DIVU) | (alu_op == OP_REMU);
  assign idle_s     = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);

  // Mul/div FSM: acc = product or partial remainder, opa = multiplicand or quotient,
  // opb = multiplier or divisor. One bit per cycle, DW cycles per op.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    rem_sel_d   = rem_sel_q;
    md_done_s   = 1'b0;
    md_result_s = '0;
    rem_shift_s = {acc_q, opa_q[DW-1]};
    trial_s     = rem_shift_s - {1'b0, opb_q};
    last_s      = (cnt_q == CW'(DW - 1));
    case (state_q)
      S_IDLE: begin
        if (accept_s && is_md_op_s) begin
          cnt_d     = '0;
          acc_d     = '0;
          opa_d     = a_s;
          opb_d     = b_s;
          rem_sel_d = (alu_op == OP_REMU);
          if (alu_op == OP_MUL) begin
            state_d = S_MUL;
          end else begin
            state_d = S_DIV;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        acc_d = opb_q[0] ? (acc_q + opa_q) : acc_q;
        opa_d = opa_q << 1;
        opb_d = opb_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (last_s) begin
          md_done_s   = 1'b1;
          md_result_s = acc_d;
          state_d     = S_IDLE;
        end else begin
          state_d = S_MUL;
        end
      end
      S_DIV: begin
        // A borrow out of the trial subtraction means the divisor did not fit.
        if (!trial_s[DW]) begin
          acc_d = trial_s[DW-1:0];
          opa_d = {opa_q[DW-2:0], 1'b1};
        end else begin
          acc_d = rem_shift_s[DW-1:0];
          opa_d = {opa_q[DW-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (last_s) begin
          md_done_s   = 1'b1;
          md_result_s = rem_sel_q ? acc_d : opa_d;
          state_d     = S_IDLE;
        end else begin
          state_d = S_DIV;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Mul/div state and iteration registers; reset aborts any op in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      rem_sel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      rem_sel_q <= rem_sel_d;
    end
  end
`else
  assign is_md_op_s  = 1'b0;
  assign md_done_s   = 1'b0;
  assign md_result_s = '0;
  assign idle_s      = 1'b1;
  assign busy        = 1'b0;
`endif

  // Output register update: load on accept (ALU result deferred for mul/div),
  // load the mul/div result when it completes, otherwise hold.
  always_comb begin
    out_valid_d = out_valid_q & ~out_ready;
    alu_res_d   = alu_res_q;
    wdata_d     = wdata_q;
    new_pc_d    = new_pc_q;
    br_taken_d  = br_taken_q;
    if (accept_s) begin
      wdata_d    = w_s;
      new_pc_d   = pc_s;
      br_taken_d = taken_s;
      if (is_md_op_s) begin
        alu_res_d = alu_res_q;
      end else begin
        alu_res_d   = alu_s;
        out_valid_d = 1'b1;
      end
    end else if (md_done_s) begin
      alu_res_d   = md_result_s;
      out_valid_d = 1'b1;
    end else begin
      alu_res_d = alu_res_q;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      alu_res_q   <= '0;
      wdata_q     <= '0;
      new_pc_q    <= '0;
      br_taken_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      alu_res_q   <= alu_res_d;
      wdata_q     <= wdata_d;
      new_pc_q    <= new_pc_d;
      br_taken_q  <= br_taken_d;
    end
  end

  assign out_valid = out_valid_q;
  assign alu_res   = alu_res_q;
  assign wdata     = wdata_q;
  assign new_pc    = new_pc_q;
  assign br_taken  = br_taken_q;

endmodule

// File: tb/tb_exe_stage_mc.sv
// Testbench for exe_stage_mc: directed vector table, hand-written backpressure and
// reset-abort sequences, and randomized ops checked against an arithmetic model.
`timescale 1ns/1ps
module tb_exe_stage_mc;

  localparam int DW = 16;
`ifdef EXE_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready, br_taken, busy;
  logic [DW-1:0] rdata1, rdata2, imme, pc_src, alu_back, wb_data;
  logic [DW-1:0] alu_res, wdata, new_pc;
  logic [3:0]    alu_op;
  logic [1:0]    ctrl_b, fwd_a, fwd_b, fwd_w, j_or_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exe_stage_mc #(.DW(DW), .BR_SHIFT(2), .PC_INC(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rdata1(rdata1), .rdata2(rdata2), .imme(imme), .pc_src(pc_src),
    .alu_op(alu_op), .ctrl_b(ctrl_b), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .fwd_w(fwd_w), .j_or_b(j_or_b), .alu_back(alu_back), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .alu_res(alu_res),
    .wdata(wdata), .new_pc(new_pc), .br_taken(br_taken), .busy(busy)
  );

  typedef struct {
    logic [3:0]  op;
    logic [1:0]  cb, fa, fb, fw, jb;
    logic [15:0] r1, r2, imm, pc, ab, wb;
  } in_t;

  typedef struct {
    in_t         i;
    logic [15:0] e_alu, e_w, e_pc;
    logic        e_tk;
  } vec_t;

  function automatic in_t mk(input logic [3:0] op, input logic [1:0] cb, fa, fb, fw, jb,
                             input logic [15:0] r1, r2, imm, pc, ab, wb);
    in_t v;
    v.op = op; v.cb = cb; v.fa = fa; v.fb = fb; v.fw = fw; v.jb = jb;
    v.r1 = r1; v.r2 = r2; v.imm = imm; v.pc = pc; v.ab = ab; v.wb = wb;
    return v;
  endfunction

  function automatic vec_t mkv(input in_t i, input logic [15:0] ea, ew, ep, input logic et);
    vec_t t;
    t.i = i; t.e_alu = ea; t.e_w = ew; t.e_pc = ep; t.e_tk = et;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model (spec rules in plain arithmetic) ----------------
  function automatic int unsigned pick(input logic [1:0] s, input int unsigned nat, ab, wb);
    case (s)
      2'd0:    return nat;
      2'd1:    return ab;
      2'd2:    return wb;
      default: return 0;
    endcase
  endfunction

  function automatic void model(input in_t v, output logic [15:0] ea, ew, ep, output logic et);
    int unsigned a, b, bn, sh, r, tgt, seq;
    a  = pick(v.fa, v.r1, v.ab, v.wb);
    bn = (v.cb == 2'd0) ? v.r2 : ((v.cb == 2'd1) ? v.imm : 0);
    b  = pick(v.fb, bn, v.ab, v.wb);
    ew = 16'(pick(v.fw, v.r2, v.ab, v.wb));
    sh = b % 16;
    case (v.op)
      4'h0:    r = (a + b) % 65536;
      4'h1:    r = (a + 65536 - b) % 65536;
      4'h2:    r = a & b;
      4'h3:    r = a | b;
      4'h4:    r = (65536 - a) % 65536;
      4'h5:    r = 65535 - a;
      4'h6:    r = (a << sh) % 65536;
      4'h7:    r = a >> sh;
      4'h8:    r = (a >> sh) | ((a >= 32768) ? (65535 - (65535 >> sh)) : 0);
      4'h9:    r = (a < b) ? 1 : 0;
      4'hA:    r = (a != b) ? 1 : 0;
      4'hB:    r = v.pc;
      4'hC:    r = MD ? ((a * b) % 65536) : 0;
      4'hD:    r = MD ? ((b == 0) ? 65535 : a / b) : 0;
      4'hE:    r = MD ? ((b == 0) ? a : a % b) : 0;
      default: r = 0;
    endcase
    ea  = 16'(r);
    tgt = (v.pc + v.imm * 4) % 65536;
    seq = (v.pc + 4) % 65536;
    case (v.jb)
      2'd0:    begin ep = 16'(tgt); et = 1'b1; end
      2'd1:    begin ep = 16'(a);   et = 1'b1; end
      2'd2:    begin ep = (a == 0) ? 16'(tgt) : 16'(seq); et = (a == 0); end
      default: begin ep = (a != 0) ? 16'(tgt) : 16'(seq); et = (a != 0); end
    endcase
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive(input in_t v);
    alu_op = v.op; ctrl_b = v.cb; fwd_a = v.fa; fwd_b = v.fb; fwd_w = v.fw; j_or_b = v.jb;
    rdata1 = v.r1; rdata2 = v.r2; imme = v.imm; pc_src = v.pc; alu_back = v.ab; wb_data = v.wb;
  endtask

  function automatic in_t rnd_in();
    in_t v;
    v.op = 4'($urandom_range(0, 15));
    v.cb = 2'($urandom_range(0, 3)); v.fa = 2'($urandom_range(0, 3));
    v.fb = 2'($urandom_range(0, 3)); v.fw = 2'($urandom_range(0, 3));
    v.jb = 2'($urandom_range(0, 3));
    v.r1 = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
    v.r2 = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
    v.imm = 16'($urandom); v.pc = 16'($urandom);
    v.ab = 16'($urandom);  v.wb = 16'($urandom);
    return v;
  endfunction

  // Issue one op from a negedge, scramble inputs after accept, wait for the result.
  task automatic run_op(input in_t v, input logic [15:0] ea, ew, ep, input logic et,
                        input string tag);
    int guard, lat, bcnt, lat_exp;
    lat_exp = (MD && v.op >= 4'hC && v.op <= 4'hE) ? DW + 1 : 1;
    drive(v);
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, "_accept"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    drive(rnd_in());
    lat = 1;
    bcnt = 0;
    while (!out_valid && lat < 60) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(lat_exp));
    chk({tag, "_busycyc"}, 32'(bcnt), 32'(lat_exp - 1));
    chk({tag, "_alu_res"}, 32'(alu_res), 32'(ea));
    chk({tag, "_wdata"}, 32'(wdata), 32'(ew));
    chk({tag, "_new_pc"}, 32'(new_pc), 32'(ep));
    chk({tag, "_br_taken"}, 32'(br_taken), 32'(et));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vec_t        tbl [19];
    in_t         rv;
    logic [15:0] ea, ew, ep;
    logic        et;

    tbl[0]  = mkv(mk(4'h0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 16'h0003, 16'h0000, 16'h0005, 16'h0200, 16'h0000, 16'h0000), 16'h0008, 16'h0000, 16'h0214, 1'b1);
    tbl[1]  = mkv(mk(4'h1, 2'b00, 2'b01, 2'b00, 2'b10, 2'b01, 16'h5555, 16'h0001, 16'h0000, 16'h0000, 16'h1234, 16'hBEEF), 16'h1233, 16'hBEEF, 16'h1234, 1'b1);
    tbl[2]  = mkv(mk(4'h0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 16'h0000, 16'h0007, 16'h0003, 16'h0100, 16'h0000, 16'h0000), 16'h0007, 16'h0007, 16'h010C, 1'b1);
    tbl[3]  = mkv(mk(4'h0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 16'h0001, 16'h0007, 16'h0003, 16'h0100, 16'h0000, 16'h0000), 16'h0008, 16'h0007, 16'h0104, 1'b0);
    tbl[4]  = mkv(mk(4'h4, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 16'h0000, 16'h00AA, 16'h0003, 16'h0100, 16'h0000, 16'h0000), 16'h0000, 16'h00AA, 16'h0104, 1'b0);
    tbl[5]  = mkv(mk(4'h8, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 16'h8000, 16'h0000, 16'h0004, 16'h0000, 16'h0000, 16'h0000), 16'hF800, 16'h0000, 16'h0010, 1'b1);
    tbl[6]  = mkv(mk(4'h6, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 16'h0001, 16'h0013, 16'h0002, 16'h0300, 16'h0000, 16'h0000), 16'h0008, 16'h0013, 16'h0308, 1'b1);
    tbl[7]  = mkv(mk(4'h9, 2'b00, 2'b10, 2'b01, 2'b01, 2'b10, 16'h0000, 16'h0000, 16'h0000, 16'h0040, 16'hFFFF, 16'h0001), 16'h0001, 16'hFFFF, 16'h0044, 1'b0);
    tbl[8]  = mkv(mk(4'hA, 2'b10, 2'b00, 2'b00, 2'b11, 2'b01, 16'h1234, 16'h5555, 16'h0000, 16'h0000, 16'h0000, 16'h0000), 16'h0001, 16'h0000, 16'h1234, 1'b1);
    tbl[9]  = mkv(mk(4'hB, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'hFFFF, 16'h0ABC, 16'h0000, 16'h0000), 16'h0ABC, 16'h0000, 16'h0AB8, 1'b1);
    tbl[10] = mkv(mk(4'hF, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 16'h1111, 16'h2222, 16'h0000, 16'h0000, 16'h0000, 16'h0000), 16'h0000, 16'h2222, 16'h0000, 1'b1);
    tbl[11] = mkv(mk(4'h7, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 16'h8000, 16'h0000, 16'h000F, 16'h0000, 16'h0000, 16'h0000), 16'h0001, 16'h0000, 16'h003C, 1'b1);
    tbl[12] = mkv(mk(4'h2, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 16'hF0F0, 16'hFF00, 16'h0000, 16'h0000, 16'h0000, 16'h0000), 16'hF000, 16'hFF00, 16'h0004, 1'b0);
    tbl[13] = mkv(mk(4'h3, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 16'h00F0, 16'h0F00, 16'h0000, 16'h0000, 16'h0000, 16'h0000), 16'h0FF0, 16'h0F00, 16'h0000, 1'b1);
    tbl[14] = mkv(mk(4'hC, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 16'h0012, 16'h0034, 16'h0000, 16'h0000, 16'h0000, 16'h0000), MD ? 16'h03A8 : 16'h0000, 16'h0034, 16'h0000, 1'b1);
    tbl[15] = mkv(mk(4'hD, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 16'h0064, 16'h0007, 16'h0000, 16'h0000, 16'h0000, 16'h0000), MD ? 16'h000E : 16'h0000, 16'h0007, 16'h0000, 1'b1);
    tbl[16] = mkv(mk(4'hE, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 16'h0064, 16'h0007, 16'h0000, 16'h0000, 16'h0000, 16'h0000), MD ? 16'h0002 : 16'h0000, 16'h0007, 16'h0000, 1'b1);
    tbl[17] = mkv(mk(4'hD, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 16'h0005, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000), MD ? 16'hFFFF : 16'h0000, 16'h0000, 16'h0000, 1'b1);
    tbl[18] = mkv(mk(4'hE, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 16'h0005, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000), MD ? 16'h0005 : 16'h0000, 16'h0000, 16'h0000, 1'b1);

    in_valid = 1'b0;
    out_ready = 1'b1;
    drive(mk(4'h0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0));
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state.
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_alu_res", 32'(alu_res), 32'd0);
    chk("rst_wdata", 32'(wdata), 32'd0);
    chk("rst_new_pc", 32'(new_pc), 32'd0);
    chk("rst_br_taken", 32'(br_taken), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Directed table; back-to-back issue also exercises consume+accept on one edge.
    for (int k = 0; k < 19; k++) begin
      run_op(tbl[k].i, tbl[k].e_alu, tbl[k].e_w, tbl[k].e_pc, tbl[k].e_tk,
             $sformatf("tbl%0d", k));
    end

    // Backpressure: hold the result 3 cycles while a new op waits.
    @(negedge clk);
    out_ready = 1'b0;
    run_op(tbl[0].i, tbl[0].e_alu, tbl[0].e_w, tbl[0].e_pc, tbl[0].e_tk, "bp_first");
    drive(tbl[1].i);
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_alu_res", 32'(alu_res), 32'h0008);
      chk("bp_new_pc", 32'(new_pc), 32'h0214);
      @(negedge clk);
    end
    out_ready = 1'b1;
    run_op(tbl[1].i, tbl[1].e_alu, tbl[1].e_w, tbl[1].e_pc, tbl[1].e_tk, "bp_release");

    // Reset mid-operation (5 cycles into a MUL).
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    drive(tbl[14].i);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    chk("abort_alu_res", 32'(alu_res), 32'd0);
    chk("abort_new_pc", 32'(new_pc), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("abort_idle_ready", 32'(in_ready), 32'd1);
    run_op(tbl[0].i, tbl[0].e_alu, tbl[0].e_w, tbl[0].e_pc, tbl[0].e_tk, "abort_next");

    // Randomized ops against the reference model.
    for (int n = 0; n < 150; n++) begin
      rv = rnd_in();
      model(rv, ea, ew, ep, et);
      run_op(rv, ea, ew, ep, et, $sformatf("rnd%0d_op%0h", n, rv.op));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
